// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: request opcodes, word formats, opcode/funct fields.
package mips_pkg;

    typedef enum logic [4:0] {
        OP_ADDU  = 5'd0,  OP_SUBU  = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3,
        OP_SLTU  = 5'd4,  OP_MFHI  = 5'd5,  OP_MFLO  = 5'd6,  OP_MULTU = 5'd7,
        OP_JR    = 5'd8,  OP_LW    = 5'd9,  OP_SW    = 5'd10, OP_BEQ   = 5'd11,
        OP_ADDIU = 5'd12, OP_ORI   = 5'd13, OP_LUI   = 5'd14, OP_BLTZ  = 5'd15,
        OP_J     = 5'd16, OP_JAL   = 5'd17, OP_MOVE  = 5'd18, OP_NOP   = 5'd19,
        OP_LI    = 5'd20
    } op_e;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_REGIMM  = 6'b000001;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_ADDIU   = 6'b001001;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic fits_s16(input logic [31:0] v);
        return (v[31:15] == '0) || (v[31:15] == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: assembles one 32-bit MIPS word in R, I or J format.
module instr_pack
    import mips_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        case (fmt_i)
            FMT_R:   word_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            FMT_I:   word_o = {op_i, rs_i, rt_i, imm16_i};
            FMT_J:   word_o = {op_i, target_i};
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Request-to-MIPS-word encoder with li expansion, immediate range checks and
// a valid/ready output stream.
module instr_encoder
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_imm,
    input  logic [25:0] req_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_EMIT2} state_e;

    state_e      state_q, state_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_last_q, out_last_d;
    logic [31:0] word2_q, word2_d;
    logic        pend2_q, pend2_d;
    logic        err_q, err_d;

    fmt_e        dec_fmt;
    logic [5:0]  dec_opc, dec_funct;
    logic [4:0]  dec_rs, dec_rt, dec_rd;
    logic [15:0] dec_imm;
    logic        dec_two, dec_bad;
    logic [31:0] word1, word2;
    logic        accept, hs, zext_ok;

    assign zext_ok = (req_imm[31:16] == '0);

    always_comb begin
        dec_fmt   = FMT_R;
        dec_opc   = OPC_SPECIAL;
        dec_funct = '0;
        dec_rs    = REG_ZERO;
        dec_rt    = REG_ZERO;
        dec_rd    = REG_ZERO;
        dec_imm   = req_imm[15:0];
        dec_two   = 1'b0;
        dec_bad   = 1'b0;
        case (req_op)
            OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLTU: begin
                dec_rs = req_rs; dec_rt = req_rt; dec_rd = req_rd;
                case (req_op)
                    OP_ADDU: dec_funct = FN_ADDU;
                    OP_SUBU: dec_funct = FN_SUBU;
                    OP_AND:  dec_funct = FN_AND;
                    OP_OR:   dec_funct = FN_OR;
                    default: dec_funct = FN_SLTU;
                endcase
            end
            OP_MFHI:  begin dec_rd = req_rd; dec_funct = FN_MFHI; end
            OP_MFLO:  begin dec_rd = req_rd; dec_funct = FN_MFLO; end
            OP_MULTU: begin dec_rs = req_rs; dec_rt = req_rt; dec_funct = FN_MULTU; end
            OP_JR:    begin dec_rs = req_rs; dec_funct = FN_JR; end
            OP_MOVE:  begin dec_rs = req_rs; dec_rd = req_rd; dec_funct = FN_ADDU; end
            OP_NOP:   dec_funct = FN_ADDU;
            OP_LW, OP_SW, OP_BEQ, OP_ADDIU: begin
                dec_fmt = FMT_I; dec_rs = req_rs; dec_rt = req_rt;
                dec_bad = !fits_s16(req_imm);
                case (req_op)
                    OP_LW:   dec_opc = OPC_LW;
                    OP_SW:   dec_opc = OPC_SW;
                    OP_BEQ:  dec_opc = OPC_BEQ;
                    default: dec_opc = OPC_ADDIU;
                endcase
            end
            OP_BLTZ: begin
                dec_fmt = FMT_I; dec_opc = OPC_REGIMM; dec_rs = req_rs;
                dec_bad = !fits_s16(req_imm);
            end
            OP_ORI: begin
                dec_fmt = FMT_I; dec_opc = OPC_ORI; dec_rs = req_rs; dec_rt = req_rt;
                dec_bad = !zext_ok;
            end
            OP_LUI: begin
                dec_fmt = FMT_I; dec_opc = OPC_LUI; dec_rt = req_rt;
                dec_bad = !zext_ok;
            end
            OP_J:   begin dec_fmt = FMT_J; dec_opc = OPC_J; end
            OP_JAL: begin dec_fmt = FMT_J; dec_opc = OPC_JAL; end
            OP_LI: begin
                dec_fmt = FMT_I; dec_rt = req_rt;
                if (zext_ok) begin
                    dec_opc = OPC_ORI;
                end else if (req_imm[31:15] == '1) begin
                    dec_opc = OPC_ADDIU;
                end else begin
                    dec_opc = OPC_LUI;
                    dec_imm = req_imm[31:16];
                    dec_two = (req_imm[15:0] != '0);
                end
            end
            default: dec_bad = 1'b1;
        endcase
    end

    instr_pack u_pack_first (
        .fmt_i    (dec_fmt),
        .op_i     (dec_opc),
        .funct_i  (dec_funct),
        .rs_i     (dec_rs),
        .rt_i     (dec_rt),
        .rd_i     (dec_rd),
        .imm16_i  (dec_imm),
        .target_i (req_target),
        .word_o   (word1)
    );

    // Second li word (ori rt,rt,lo) is built at acceptance so later req_* changes cannot leak in.
    instr_pack u_pack_second (
        .fmt_i    (FMT_I),
        .op_i     (OPC_ORI),
        .funct_i  (6'b000000),
        .rs_i     (req_rt),
        .rt_i     (req_rt),
        .rd_i     (REG_ZERO),
        .imm16_i  (req_imm[15:0]),
        .target_i (26'd0),
        .word_o   (word2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            out_instr_q <= '0;
            out_last_q  <= 1'b0;
            word2_q     <= '0;
            pend2_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_instr_q <= out_instr_d;
            out_last_q  <= out_last_d;
            word2_q     <= word2_d;
            pend2_q     <= pend2_d;
            err_q       <= err_d;
        end
    end

    assign accept = req_valid & req_ready;

    always_comb begin
        state_d     = state_q;
        out_instr_d = out_instr_q;
        out_last_d  = out_last_q;
        word2_d     = word2_q;
        pend2_d     = pend2_q;
        err_d       = accept & dec_bad;
        unique case (state_q)
            S_IDLE:  if (accept && !dec_bad) state_d = S_EMIT;
            S_EMIT: begin
                if (hs) begin
                    if (pend2_q)                state_d = S_EMIT2;
                    else if (accept && !dec_bad) state_d = S_EMIT;
                    else                        state_d = S_IDLE;
                end
            end
            S_EMIT2: if (hs) state_d = (accept && !dec_bad) ? S_EMIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept && !dec_bad) begin
            out_instr_d = word1;
            out_last_d  = !dec_two;
            word2_d     = word2;
            pend2_d     = dec_two;
        end else if (state_q == S_EMIT && hs && pend2_q) begin
            out_instr_d = word2_q;
            out_last_d  = 1'b1;
            pend2_d     = 1'b0;
        end
    end

    always_comb begin
        out_valid = (state_q != S_IDLE);
        hs        = out_valid & out_ready;
        req_ready = reset & ((state_q == S_IDLE) | (hs & out_last_q));
        out_instr = out_instr_q;
        out_last  = out_last_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed MIPS words.
module tb_instr_encoder;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [4:0]  req_op, req_rs, req_rt, req_rd;
    logic [31:0] req_imm;
    logic [25:0] req_target;
    logic        out_valid, out_ready, out_last, err;
    logic [31:0] out_instr;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_imm    (req_imm),
        .req_target (req_target),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_last   (out_last),
        .err        (err)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Presents a request at the falling edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] imm, input logic [25:0] tgt);
        @(negedge clk);
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
        req_imm = imm; req_target = tgt; req_valid = 1'b1;
        chk1("req_ready_at_send", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
        req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_out_instr", out_instr, 32'h0);
        chk1("rst_req_ready", req_ready, 1'b0);
        @(negedge clk); reset = 1'b1; #1;
        chk1("idle_req_ready", req_ready, 1'b1);

        send(OP_ADDU, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
        chk1("addu_valid", out_valid, 1'b1);
        chk32("addu_word", out_instr, 32'h00221821);
        chk1("addu_last", out_last, 1'b1);
        chk1("addu_err", err, 1'b0);
        @(posedge clk); #1;
        chk1("addu_drained", out_valid, 1'b0);

        // Back-to-back: the second request is accepted on the first word's handshake.
        send(OP_SUBU, 5'd5, 5'd6, 5'd4, 32'h0, 26'h0);
        chk32("subu_word", out_instr, 32'h00A62023);
        send(OP_SW, 5'd29, 5'd4, 5'd0, 32'hFFFFFFFC, 26'h0);
        chk32("sw_word", out_instr, 32'hAFA4FFFC);
        chk1("sw_valid", out_valid, 1'b1);
        send(OP_MOVE, 5'd9, 5'd0, 5'd7, 32'h0, 26'h0);
        chk32("move_word", out_instr, 32'h01203821);
        send(OP_MFHI, 5'd0, 5'd0, 5'd5, 32'h0, 26'h0);
        chk32("mfhi_word", out_instr, 32'h00002810);
        send(OP_BLTZ, 5'd3, 5'd0, 5'd0, 32'hFFFFFFFE, 26'h0);
        chk32("bltz_word", out_instr, 32'h0460FFFE);
        send(OP_JR, 5'd31, 5'd0, 5'd0, 32'h0, 26'h0);
        chk32("jr_word", out_instr, 32'h03E00008);
        send(OP_JAL, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0100000);
        chk32("jal_word", out_instr, 32'h0C100000);
        @(posedge clk); #1;

        send(OP_LI, 5'd0, 5'd8, 5'd0, 32'h12345678, 26'h0);
        chk32("li2_first_word", out_instr, 32'h3C081234);
        chk1("li2_first_last", out_last, 1'b0);
        chk1("li2_no_ready_mid", req_ready, 1'b0);
        req_rt = 5'd31; req_imm = 32'h0;
        @(posedge clk); #1;
        chk32("li2_second_word", out_instr, 32'h35085678);
        chk1("li2_second_last", out_last, 1'b1);
        @(posedge clk); #1;
        chk1("li2_drained", out_valid, 1'b0);

        send(OP_LI, 5'd0, 5'd10, 5'd0, 32'h00050000, 26'h0);
        chk32("li_lui_only_word", out_instr, 32'h3C0A0005);
        chk1("li_lui_only_last", out_last, 1'b1);
        send(OP_LI, 5'd0, 5'd9, 5'd0, 32'hFFFFFFF0, 26'h0);
        chk32("li_neg_word", out_instr, 32'h2409FFF0);
        chk1("li_neg_last", out_last, 1'b1);
        send(OP_LI, 5'd0, 5'd8, 5'd0, 32'h00001234, 26'h0);
        chk32("li_small_word", out_instr, 32'h34081234);
        @(posedge clk); #1;
        chk1("li_small_drained", out_valid, 1'b0);

        out_ready = 1'b0;
        send(OP_LI, 5'd0, 5'd8, 5'd0, 32'h12345678, 26'h0);
        for (int i = 0; i < 3; i++) begin
            chk1("stall_valid", out_valid, 1'b1);
            chk32("stall_word", out_instr, 32'h3C081234);
            chk1("stall_last", out_last, 1'b0);
            chk1("stall_req_ready", req_ready, 1'b0);
            @(posedge clk); #1;
        end
        chk32("stall_still_first", out_instr, 32'h3C081234);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk32("stall_second_word", out_instr, 32'h35085678);
        chk1("stall_second_last", out_last, 1'b1);
        @(posedge clk); #1;
        chk1("stall_drained", out_valid, 1'b0);

        send(OP_LW, 5'd5, 5'd4, 5'd0, 32'h00008000, 26'h0);
        chk1("lw_range_err", err, 1'b1);
        chk1("lw_range_no_valid", out_valid, 1'b0);
        chk1("lw_range_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        chk1("lw_range_err_pulse", err, 1'b0);
        chk1("lw_range_still_idle", out_valid, 1'b0);
        send(OP_ORI, 5'd1, 5'd2, 5'd0, 32'h00010000, 26'h0);
        chk1("ori_range_err", err, 1'b1);
        chk1("ori_range_no_valid", out_valid, 1'b0);
        send(5'd31, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0);
        chk1("undef_op_err", err, 1'b1);
        chk1("undef_op_no_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(OP_LI, 5'd0, 5'd8, 5'd0, 32'h12345678, 26'h0);
        chk32("rstmid_first_word", out_instr, 32'h3C081234);
        reset = 1'b0; #1;
        chk1("rstmid_valid_low", out_valid, 1'b0);
        chk32("rstmid_instr_zero", out_instr, 32'h0);
        chk1("rstmid_ready_low", req_ready, 1'b0);
        @(negedge clk); reset = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk1("rstmid_no_second", out_valid, 1'b0);
        end
        chk1("rstmid_ready_after", req_ready, 1'b1);
        send(OP_NOP, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0);
        chk32("nop_word", out_instr, 32'h00000021);
        chk1("nop_last", out_last, 1'b1);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Ports SHALL be as follows; the design has one clock, and reset is asynchronous and active-low:
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when high with req_valid
- req_op  input  5  operation code (mips_pkg enum)
- req_rs, req_rt, req_rd  input  5 each  register fields
- req_imm  input  32  immediate / li constant
- req_target  input  26  jump target field
- out_valid  output  1  out_instr holds a valid word
- out_ready  input  1  consumer takes the word when high with out_valid
- out_instr  output  32  encoded MIPS word
- out_last  output  1  word is the last of its request's expansion
- err  output  1  one-cycle pulse: request rejected

Function
REQ-002 Word formats SHALL be R = {0,rs,rt,rd,5'b0,funct}, I = {op,rs,rt,imm16}, J = {op,target26}.
REQ-003 Single-word encodings SHALL be:
- R-type: addu 100001, subu 100011, and 100100, or 100101, sltu 101011, mfhi 010000 (rd only), mflo 010010 (rd only), multu 011001 (rs,rt only), jr 001000 (rs only).
- I-type opcodes: lw 100011, sw 101011, beq 000100, addiu 001001, ori 001101.
- lui 001111 with rs=0; bltz 000001 with rt=0.
- J-type opcodes: j 000010, jal 000011.
- Unused fields SHALL be 0.
REQ-004 Pseudo-ops SHALL expand as follows:
- move: addu rd,rs,$0.
- nop: addu $0,$0,$0.
- li rt,imm: if imm[31:16]==0, one word, ori rt,$0,imm[15:0].
- li, else if imm[31:15] is all ones, one word, addiu rt,$0,imm[15:0].
- li, else: lui rt,imm[31:16]; then, only if imm[15:0]!=0, ori rt,rt,imm[15:0].
REQ-005 Immediate range checks SHALL be:
- addiu, lw, sw, beq, bltz: req_imm must be the sign extension of req_imm[15:0].
- ori, lui: req_imm[31:16] must be 0.
- Any violation, or an undefined req_op, SHALL consume the request, pulse err the next cycle, and emit no word.
REQ-006 FSM states SHALL be IDLE, EMIT, EMIT2, with these transitions:
- IDLE --accept--> EMIT, or IDLE if err.
- EMIT --handshake and second word pending--> EMIT2.
- EMIT --handshake and no second word--> IDLE, or EMIT if a new request is accepted in the same cycle.
- EMIT2 --handshake--> IDLE, or EMIT on a same-cycle accept.
REQ-007 Latency: a request accepted at edge N SHALL present its first word with out_valid=1 in the cycle after edge N.
REQ-008 req_ready SHALL equal (state==IDLE) OR (out_valid AND out_ready AND out_last), giving back-to-back throughput of one word per cycle.
REQ-009 While out_valid=1 and out_ready=0, out_instr and out_last SHALL hold stable, and the second word of an li SHALL NOT appear.
REQ-010 out_last SHALL be 1 on every single-word emission and on the second li word, and 0 on the first word of a two-word li.
REQ-011 All request fields SHALL be registered at acceptance; later changes to req_* SHALL NOT affect words already in flight.
REQ-012 err and out_valid SHALL never be high in the same cycle for the same request.

Reset
REQ-013 While reset=0: state=IDLE, out_valid=0, out_last=0, err=0, out_instr=0, req_ready=0.
REQ-014 Reset asserted mid-expansion SHALL discard any pending second word; after release, the first request is accepted in IDLE.

Structure
REQ-015 Package mips_pkg SHALL hold the req_op enum, all 6-bit opcode and funct constants, and the register-zero constant, shared with Decoder.
REQ-016 One combinational sub-module, instr_pack, SHALL build a single 32-bit word from (op, rs, rt, rd, imm16, target); the FSM, expansion and range checks stay in instr_encoder.

Verification
REQ-017 addu rd=3,rs=1,rt=2 with out_ready=1 -> out_instr=0x00221821, out_last=1, one cycle after accept.
REQ-018 li rt=8, imm=0x12345678 -> 0x3C081234 (out_last=0) then 0x35085678 (out_last=1); with li rt=10, imm=0x00050000 -> only 0x3C0A0005 (out_last=1).
REQ-019 li rt=9, imm=0xFFFFFFF0 -> single word 0x2409FFF0; jal target=0x0100000 -> 0x0C100000.
REQ-020 li 0x12345678 with out_ready held low 3 cycles -> 0x3C081234 held stable for all 3 cycles, second word only after the first handshake, req_ready=0 throughout.
REQ-021 lw rt=4,rs=5, imm=0x00008000 -> err=1 for one cycle, out_valid stays 0, req_ready=1 again the following cycle.
REQ-022 reset pulsed low after the first li word is accepted -> out_valid=0 immediately and no 0x35085678 emitted after release.
